// File: rtl/leo_sprite_fetch.sv
// Sprite fetch for Leo: beam-vs-sprite hit test, walk-animation ROM addressing, 3-stage pixel pipeline.
// Optional build macro SPRITE_FLIP_EN enables horizontal mirroring latched from facing_left at vsync.
module leo_sprite_fetch #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int FRAMES     = 2,
  parameter int ANIM_DIV   = 8,
  parameter int TRANSP_IDX = 0,
  localparam int ADDR_W    = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int FRAME_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [9:0]         SpriteX,
  input  logic [9:0]         SpriteY,
  input  logic               moving,
  input  logic               facing_left,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [3:0]         rom_q,
  output logic [3:0]         pixel_index,
  output logic               pixel_valid,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [10:0]       w_rel_x;
  logic [10:0]       w_rel_y;
  logic [10:0]       w_col;
  logic              w_hit;
  logic              w_vs_rise;
  logic [ADDR_W-1:0] w_frame_base;
  logic [ADDR_W-1:0] w_addr;

  logic              r_frame_clk_d;
  logic              r_hit1;
  logic              r_hit2;
  logic [DIV_W-1:0]  r_div;

  // Zero-extended 11-bit difference; bit 10 set means the beam is left of / above the box.
  assign w_rel_x = {1'b0, DrawX} - {1'b0, SpriteX};
  assign w_rel_y = {1'b0, DrawY} - {1'b0, SpriteY};

  assign w_hit = ~w_rel_x[10] && (w_rel_x < 11'(SPR_W)) &&
                 ~w_rel_y[10] && (w_rel_y < 11'(SPR_H));

`ifdef SPRITE_FLIP_EN
  logic r_flip_q;
  assign w_col = r_flip_q ? (11'(SPR_W - 1) - w_rel_x) : w_rel_x;
`else
  logic w_unused_facing;
  assign w_unused_facing = facing_left;
  assign w_col           = w_rel_x;
`endif

  assign w_frame_base = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H);
  assign w_addr       = w_hit ? (w_frame_base + ADDR_W'(w_rel_y) * ADDR_W'(SPR_W) + ADDR_W'(w_col))
                              : w_frame_base;

  assign w_vs_rise = frame_clk & ~r_frame_clk_d;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr    <= '0;
      r_hit1      <= 1'b0;
      r_hit2      <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_index <= 4'(TRANSP_IDX);
    end else begin
      rom_addr    <= w_addr;
      r_hit1      <= w_hit;
      r_hit2      <= r_hit1;
      pixel_valid <= r_hit2 && (rom_q != 4'(TRANSP_IDX));
      pixel_index <= r_hit2 ? rom_q : 4'(TRANSP_IDX);
    end
  end

  // Animation and mirror state only move on the vsync rising edge, never mid-frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_frame_clk_d <= 1'b0;
      r_div         <= '0;
      anim_frame    <= '0;
`ifdef SPRITE_FLIP_EN
      r_flip_q      <= 1'b0;
`endif
    end else begin
      r_frame_clk_d <= frame_clk;
      if (w_vs_rise) begin
`ifdef SPRITE_FLIP_EN
        r_flip_q <= facing_left;
`endif
        if (moving) begin
          if (r_div == DIV_W'(ANIM_DIV - 1)) begin
            r_div      <= '0;
            anim_frame <= (anim_frame == FRAME_W'(FRAMES - 1)) ? '0 : anim_frame + FRAME_W'(1);
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end else begin
          r_div      <= '0;
          anim_frame <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_leo_sprite_fetch.sv
// Scoreboard bench for leo_sprite_fetch: bench-side ROM, address/pixel model and vsync animation model.
module tb_leo_sprite_fetch;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
  logic        moving;
  logic        facing_left;
  logic [10:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  pixel_index;
  logic        pixel_valid;
  logic [0:0]  anim_frame;

  leo_sprite_fetch dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
    .moving(moving), .facing_left(facing_left),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .pixel_index(pixel_index), .pixel_valid(pixel_valid), .anim_frame(anim_frame)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  logic [3:0] mem [0:2047];
  always @(posedge Clk) rom_q <= mem[rom_addr];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int due; logic [10:0] addr; } addr_exp_t;
  typedef struct { int due; logic valid; logic [3:0] idx; } pix_exp_t;
  addr_exp_t addr_q[$];
  pix_exp_t  pix_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  int m_frame = 0;
  int m_div   = 0;
  int m_flip  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_due();
    addr_exp_t ea;
    pix_exp_t  ep;
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      ea = addr_q.pop_front();
      check("rom_addr", 32'(rom_addr), 32'(ea.addr));
    end
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      ep = pix_q.pop_front();
      check("pixel_valid", 32'(pixel_valid), 32'(ep.valid));
      check("pixel_index", 32'(pixel_index), 32'(ep.idx));
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    check_due();
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  // Drive one beam position and predict its address (1 edge later) and pixel (3 edges later).
  task automatic drive_pix(input int x, input int y, input int sx, input int sy);
    int rx, ry, col, a;
    logic hit;
    addr_exp_t ea;
    pix_exp_t  ep;
    tick();
    DrawX = 10'(x); DrawY = 10'(y); SpriteX = 10'(sx); SpriteY = 10'(sy);
    rx  = x - sx;
    ry  = y - sy;
    hit = (rx >= 0) && (rx < 32) && (ry >= 0) && (ry < 32);
    col = (m_flip != 0) ? 31 - rx : rx;
    a   = m_frame * 1024 + (hit ? ry * 32 + col : 0);
    ea.due = cyc + 1; ea.addr = 11'(a);
    ep.due = cyc + 3; ep.valid = hit && (mem[a] != 4'd0); ep.idx = hit ? mem[a] : 4'd0;
    addr_q.push_back(ea);
    pix_q.push_back(ep);
  endtask

  task automatic model_vs_rise();
    if (moving) begin
      if (m_div == 7) begin
        m_div   = 0;
        m_frame = (m_frame + 1) % 2;
      end else begin
        m_div++;
      end
    end else begin
      m_div   = 0;
      m_frame = 0;
    end
`ifdef SPRITE_FLIP_EN
    m_flip = int'(facing_left);
`endif
  endtask

  task automatic vsync();
    drain();
    frame_clk = 1'b1;
    model_vs_rise();
    tick();
    frame_clk = 1'b0;
    tick();
  endtask

  initial begin
    int x, y, sx, sy;
    for (int i = 0; i < 2048; i++) mem[i] = 4'((i * 7 + 3) % 16);
    mem[0] = 4'd5; mem[1023] = 4'd9; mem[33] = 4'd0; mem[34] = 4'd1; mem[1024] = 4'd7;
    Reset = 1'b1; frame_clk = 1'b0; moving = 1'b0; facing_left = 1'b0;
    DrawX = '0; DrawY = '0; SpriteX = 10'd100; SpriteY = 10'd50;
    repeat (2) @(negedge Clk);
    check("reset_rom_addr", 32'(rom_addr), 0);
    check("reset_valid", 32'(pixel_valid), 0);
    check("reset_index", 32'(pixel_index), 0);
    check("reset_anim", 32'(anim_frame), 0);
    Reset = 1'b0;

    // Corner, box edges, wrap, transparency
    drive_pix(100, 50, 100, 50);
    drive_pix(131, 81, 100, 50);
    drive_pix(132, 81, 100, 50);
    drive_pix(99, 50, 100, 50);
    drive_pix(131, 50, 100, 50);
    drive_pix(100, 81, 100, 50);
    drive_pix(100, 82, 100, 50);
    drive_pix(100, 49, 100, 50);
    drive_pix(639, 10, 0, 0);
    drive_pix(0, 0, 0, 0);
    drive_pix(101, 51, 100, 50);
    drive_pix(102, 51, 100, 50);
    for (int i = 0; i < 48; i++) begin
      sx = int'($urandom_range(0, 600));
      sy = int'($urandom_range(0, 440));
      x  = sx + int'($urandom_range(0, 40)) - 4;
      y  = sy + int'($urandom_range(0, 40)) - 4;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      drive_pix(x, y, sx, sy);
    end
    drain();

    // Animation stepping
    moving = 1'b1;
    repeat (8) vsync();
    check("anim_after_8", 32'(anim_frame), 1);
    drive_pix(100, 50, 100, 50);
    drive_pix(131, 81, 100, 50);
    repeat (8) vsync();
    check("anim_after_16", 32'(anim_frame), 0);
    drain();
    frame_clk = 1'b1;
    model_vs_rise();
    repeat (100) tick();
    check("anim_hold_high", 32'(anim_frame), 0);
    frame_clk = 1'b0;
    tick();
    repeat (6) vsync();
    check("anim_hold_one_step", 32'(anim_frame), 0);
    vsync();
    check("anim_after_hold", 32'(anim_frame), 1);
    moving = 1'b0;
    tick();
    check("anim_stop_pending", 32'(anim_frame), 1);
    vsync();
    check("anim_stand", 32'(anim_frame), 0);

    // Mid-line reset
    moving = 1'b1;
    repeat (8) vsync();
    drive_pix(100, 50, 100, 50);
    repeat (3) tick();
    #2 Reset = 1'b1;
    #1;
    check("midreset_valid", 32'(pixel_valid), 0);
    check("midreset_index", 32'(pixel_index), 0);
    check("midreset_anim", 32'(anim_frame), 0);
    check("midreset_addr", 32'(rom_addr), 0);
    addr_q.delete();
    pix_q.delete();
    m_frame = 0; m_div = 0; m_flip = 0;
    moving = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    drive_pix(131, 81, 100, 50);
    drain();

    // Mirroring latched only at vsync
    facing_left = 1'b1;
    vsync();
    drive_pix(100, 50, 100, 50);
    facing_left = 1'b0;
    drive_pix(100, 50, 100, 50);
    drive_pix(131, 81, 100, 50);
    drive_pix(131, 51, 100, 50);
    vsync();
    drive_pix(100, 50, 100, 50);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
